// File: rtl/acc_drain_if.sv
// acc_drain package and bundle: column-capture inputs plus the
// tagged valid/ready output stream.
package acc_drain_pkg;
  localparam int pkg_N = 4;
endpackage

interface acc_drain_if #(
  parameter int N = acc_drain_pkg::pkg_N,
  parameter int W = 16
);
  localparam int CW = $clog2(N);

  logic [N-1:0]   acc_valid;
  logic [N*W-1:0] acc_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_col;
  logic [CW-1:0]  out_row;

  modport master (
    output acc_valid, acc_data, out_ready,
    input  out_valid, out_data, out_col, out_row
  );

  modport slave (
    input  acc_valid, acc_data, out_ready,
    output out_valid, out_data, out_col, out_row
  );
endinterface

// File: rtl/acc_drain.sv
// acc_drain: per-column result FIFOs drained round-robin onto one
// row/column-tagged stream, with tile completion and overflow flags.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int N     = pkg_N,
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  acc_drain_if.slave   bus,
  output logic [N-1:0] overflow_o,
  output logic         done_o
);

  localparam int CW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(N*N) + 1;

  typedef logic [CW+W-1:0] ent_t;

  ent_t mem_q [N][DEPTH];

  logic [N-1:0][AW-1:0] wr_q, wr_d;
  logic [N-1:0][AW-1:0] rd_q, rd_d;
  logic [N-1:0][AW:0]   cnt_q, cnt_d;
  logic [N-1:0][CW-1:0] row_q, row_d;
  logic [N-1:0]         ovf_q, ovf_d;
  logic [N-1:0]         push, pop;
  logic [N-1:0]         nempty, full;
  logic [CW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        sel_q, sel_d;
  logic [CW-1:0]        pick, sel, idx;
  logic                 lock_q, lock_d;
  logic                 found, valid, hs;
  logic [SW-1:0]        sent_q, sent_d;
  logic                 done_q, done_d;
  ent_t                 head;
  int                   j;

  always_comb begin
    for (int c = 0; c < N; c++) begin
      nempty[c] = (cnt_q[c] != '0);
      full[c]   = (cnt_q[c] == (AW+1)'(DEPTH));
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_q) + i;
      if (j >= N) j = j - N;
      idx = CW'(j);
      if (!found && nempty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // A stalled word keeps its column even if a higher-priority one fills
  assign sel   = lock_q ? sel_q : pick;
  assign valid = |nempty;
  assign hs    = valid & bus.out_ready;
  assign head  = mem_q[sel][rd_q[sel]];

  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? head[W-1:0] : '0;
  assign bus.out_row   = valid ? head[W +: CW] : '0;
  assign bus.out_col   = valid ? sel : '0;
  assign overflow_o    = ovf_q;
  assign done_o        = done_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    row_d  = row_q;
    ovf_d  = ovf_q;
    push   = '0;
    pop    = '0;
    rr_d   = rr_q;
    sel_d  = sel;
    lock_d = valid & ~bus.out_ready;
    sent_d = sent_q;
    done_d = done_q;
    for (int c = 0; c < N; c++) begin
      pop[c]  = hs && (sel == CW'(c));
      push[c] = bus.acc_valid[c] && !clear_i
                && (!full[c] || pop[c]);
      if (bus.acc_valid[c] && !clear_i) begin
        if (full[c] && !pop[c]) ovf_d[c] = 1'b1;
        row_d[c] = (row_q[c] == CW'(N-1))
                   ? '0 : row_q[c] + CW'(1);
      end
      if (push[c]) wr_d[c] = wr_q[c] + AW'(1);
      if (pop[c])  rd_d[c] = rd_q[c] + AW'(1);
      cnt_d[c] = cnt_q[c] + (AW+1)'(push[c])
                 - (AW+1)'(pop[c]);
    end
    if (hs) begin
      rr_d = (sel == CW'(N-1)) ? '0 : sel + CW'(1);
      if (sent_q != SW'(N*N)) sent_d = sent_q + SW'(1);
      if (sent_q == SW'(N*N-1)) done_d = 1'b1;
    end
    if (clear_i) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      row_d  = '0;
      rr_d   = '0;
      lock_d = 1'b0;
      sent_d = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N; c++) begin
      if (push[c])
        mem_q[c][wr_q[c]] <= {row_q[c], bus.acc_data[c*W +: W]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      row_q  <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
      sent_q <= '0;
      done_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      sel_q  <= sel_d;
      lock_q <= lock_d;
      sent_q <= sent_d;
      done_q <= done_d;
    end
  end

endmodule

// File: doc/acc_drain.md
# acc_drain

Output drain stage sitting directly downstream of the array `controller`. It captures per-column accumulator results on the cycles the controller raises `acc_valid` for a column, and buffers them in per-column FIFOs. It serialises them onto a single valid/ready stream tagged with row/column coordinates. It signals completion once all N×N results of a tile have left the block.

## Interface
Parameters:
- `N`, default 4 (`pkg_N`): array dimension; number of columns and rows.
- `W`, default 16: accumulator result width.
- `DEPTH`, default 4: entries per column FIFO; must be a power of two ≥ 2.

Ports:
- `clk_i`, input, 1: clock. All state is updated on the rising edge.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `clear_i`, input, 1: synchronous tile restart. Has the same effect as reset except that `overflow_o` is kept.
- `acc_valid_i`, input, N: bit c set means column c presents a result this cycle. Multiple bits may be high together.
- `acc_data_i`, input, N*W: column c result is bits [c*W +: W].
- `out_valid_o`, output, 1: output word available.
- `out_ready_i`, input, 1: consumer accepts the word.
- `out_data_o`, output, W: result value.
- `out_col_o`, output, log2(N): source column.
- `out_row_o`, output, log2(N): row index within the column.
- `overflow_o`, output, N: sticky flag per column; set when a result was dropped.
- `done_o`, output, 1: level signal; high once N*N words have been handed off.

## Operation
- **Capture:**
  - On each edge with `acc_valid_i[c]` = 1, push {row_cnt[c], `acc_data_i` slice c} into FIFO c.
  - Then row_cnt[c] increments, wrapping modulo N.
- **Full FIFO:**
  - A push into a full FIFO is accepted only if that FIFO pops on the same edge.
  - Otherwise the value is dropped, row_cnt[c] still increments, and `overflow_o[c]` is set.
  - `overflow_o` clears only on `rst_ni`.
- **Arbitration:**
  - Round-robin over non-empty FIFOs.
  - The search starts at pointer `rr`, whose reset value is 0. After a handshake from column c, `rr` becomes (c+1) mod N.
- **Selection lock:** while `out_valid_o` && !`out_ready_i`, the selected column is held. `out_data_o`, `out_col_o` and `out_row_o` must remain stable until the handshake.
- **Output:**
  - `out_valid_o` = 1 whenever any FIFO is non-empty.
  - The data comes from the head of the selected FIFO, driven combinationally from registered storage.
- **Handshake:** occurs when `out_valid_o` && `out_ready_i` on an edge. That edge pops the selected FIFO.
- **Completion:**
  - `sent_cnt` (width log2(N*N)+1) increments on each handshake.
  - `done_o` goes high on the edge where `sent_cnt` reaches N*N, and stays high until reset or `clear_i`.
  - Handshakes after `done_o` are still served, and `sent_cnt` saturates.
- **`clear_i`:**
  - Empties all FIFOs and zeroes row_cnt, `rr`, `sent_cnt` and `done_o`.
  - Any `acc_valid_i` in the same cycle is ignored.
- **Reset values:**
  - `out_valid_o`=0, `overflow_o`=0, `done_o`=0.
  - `out_data_o`, `out_col_o` and `out_row_o` are 0 whenever all FIFOs are empty.
  - All pointers and counters are 0.

## Timing
- **Latency:** capture edge to `out_valid_o` high is 1 cycle, i.e. the result is visible in the cycle after the capture edge.
- **Throughput:** one word per cycle at the output. Sustained input above one word per cycle fills the FIFOs.
- **Controller drain pattern:** for N=4 the controller's shifting mask drives the column-valid bits with these counts per cycle: 1, 2, 3, 4, 3, 2, 1 (16 results over 7 cycles). With DEPTH=4 and `out_ready_i` held high, no overflow may occur.
- **Simultaneous push and pop on one FIFO:** occupancy is unchanged. This holds when the FIFO is full.
- **Asynchronous reset mid-stream:**
  - All outputs drop to reset values immediately, without waiting for a clock edge.
  - In-flight data is lost.
  - The first edge after release of `rst_ni` may capture.

## Test plan
1. **Reset then single result:**
   - Stimulus: reset, then `acc_valid_i`=4'b0001 with column 0 = 0x1234 for one cycle, `out_ready_i`=1.
   - Required: next cycle `out_valid_o`=1, `out_data_o`=0x1234, `out_col_o`=0, `out_row_o`=0; the cycle after, `out_valid_o`=0.
2. **Full controller drain pattern:**
   - Stimulus: apply the 1/2/3/4/3/2/1 pattern with column c row r data = 16*c+r, `out_ready_i`=1.
   - Required: exactly 16 words, each (c,r) once, values match; `done_o` rises on the 16th handshake; `overflow_o`=0.
3. **Backpressure stability:**
   - Stimulus: fill column 2 with 3 words while `out_ready_i`=0 for 5 cycles.
   - Required: `out_data_o`, `out_col_o`=2 and `out_row_o`=0 stay constant; release drains rows 0, 1, 2 in order.
4. **Overflow:**
   - Stimulus: `out_ready_i`=0, push column 1 five times (DEPTH=4).
   - Required: `overflow_o`=4'b0010 after the fifth push; drain returns rows 0–3 only; the flag persists through `clear_i`.
5. **Round-robin fairness:**
   - Stimulus: columns 0 and 3 each hold 2 words, `out_ready_i`=1.
   - Required: output column order is 0, 3, 0, 3.
6. **Async reset mid-drain:**
   - Stimulus: assert `rst_ni`=0 between clock edges with 6 words buffered.
   - Required: `out_valid_o`=0 and `done_o`=0 before the next edge; after release, a fresh single push appears with `out_row_o`=0.
